// File: rtl/rr_arbiter_sync.sv
// rr_arbiter_sync
//   Clocked round-robin arbiter for N requesters. A winner keeps the grant
//   until it signals done, drops its request, or (when MAX_HOLD != 0) has
//   held for MAX_HOLD cycles while someone else is waiting. On release the
//   priority pointer moves to the slot after the old owner. The pointer does
//   not move when a grant is issued from IDLE.
// Ports
//   clk        rising-edge clock
//   n_reset    synchronous active-low reset
//   request    per-requester request levels
//   done       owner finished (only looked at while valid)
//   grant      registered one-hot grant, zero when idle
//   grant_idx  index of the current owner (meaningful while valid)
//   valid      a grant is active
module rr_arbiter_sync #(
    parameter int N        = 4,
    parameter int HANDOVER = 1,
    parameter int MAX_HOLD = 0,
    localparam int W       = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         n_reset,
    input  logic [N-1:0] request,
    input  logic         done,
    output logic [N-1:0] grant,
    output logic [W-1:0] grant_idx,
    output logic         valid
);

    localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HW-1:0] HOLD_LIM = HW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

    typedef enum logic {IDLE, OWNED} state_t;

    state_t        state_q;
    logic [N-1:0]  grant_q;
    logic [W-1:0]  grant_idx_q;
    logic          valid_q;
    logic [W-1:0]  ptr_q;
    logic [HW-1:0] hold_cnt_q;

    // First set bit of v, scanning s, s+1, ... modulo N.
    function automatic logic [W-1:0] pick(input logic [N-1:0] v, input logic [W-1:0] s);
        logic [W-1:0] r;
        logic [W-1:0] idx;
        logic         found;
        r     = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = W'((int'(s) + k) % N);
            if (!found && v[idx]) begin
                r     = idx;
                found = 1'b1;
            end
        end
        return r;
    endfunction

    logic [N-1:0] others;
    logic [W-1:0] nxt_idx;
    logic [W-1:0] win_idle;
    logic [W-1:0] win_ho;
    logic         tmo;
    logic         rel;

    assign others   = request & ~grant_q;
    assign nxt_idx  = (int'(grant_idx_q) >= N - 1) ? '0 : grant_idx_q + W'(1);
    assign win_idle = pick(request, ptr_q);
    // Handover search starts after the old owner, so it can never win again here.
    assign win_ho   = pick(others, nxt_idx);
    // Timeout only matters when someone else is actually waiting.
    assign tmo      = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LIM) && (|others);
    assign rel      = done | ~request[grant_idx_q] | tmo;

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            grant_idx_q <= '0;
            valid_q     <= 1'b0;
            ptr_q       <= '0;
            hold_cnt_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|request) begin
                        grant_q     <= N'(1) << win_idle;
                        grant_idx_q <= win_idle;
                        valid_q     <= 1'b1;
                        hold_cnt_q  <= '0;
                        state_q     <= OWNED;
                    end
                end
                OWNED: begin
                    if (rel) begin
                        ptr_q <= nxt_idx;
                        if ((HANDOVER != 0) && (|others)) begin
                            grant_q     <= N'(1) << win_ho;
                            grant_idx_q <= win_ho;
                            hold_cnt_q  <= '0;
                        end else begin
                            // grant_idx keeps the old owner while idle
                            grant_q <= '0;
                            valid_q <= 1'b0;
                            state_q <= IDLE;
                        end
                    end else if ((MAX_HOLD != 0) && (hold_cnt_q != HOLD_LIM)) begin
                        hold_cnt_q <= hold_cnt_q + HW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign grant     = grant_q;
    assign grant_idx = grant_idx_q;
    assign valid     = valid_q;

endmodule

// File: tb/tb_rr_arbiter_sync.sv
// Bench for rr_arbiter_sync. Three instances share the stimulus:
//   a: HANDOVER=1, MAX_HOLD=0   b: HANDOVER=0, MAX_HOLD=0   c: HANDOVER=1, MAX_HOLD=4
// Expected grants are queued when a cycle's stimulus is applied and popped
// after the edge for comparison.
module tb_rr_arbiter_sync;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       n_reset;
    logic [3:0] request;
    logic       done;

    logic [3:0] g_a, g_b, g_c;
    logic [1:0] i_a, i_b, i_c;
    logic       v_a, v_b, v_c;

    rr_arbiter_sync #(.N(4), .HANDOVER(1), .MAX_HOLD(0)) dut_a (
        .clk(clk), .n_reset(n_reset), .request(request), .done(done),
        .grant(g_a), .grant_idx(i_a), .valid(v_a));
    rr_arbiter_sync #(.N(4), .HANDOVER(0), .MAX_HOLD(0)) dut_b (
        .clk(clk), .n_reset(n_reset), .request(request), .done(done),
        .grant(g_b), .grant_idx(i_b), .valid(v_b));
    rr_arbiter_sync #(.N(4), .HANDOVER(1), .MAX_HOLD(4)) dut_c (
        .clk(clk), .n_reset(n_reset), .request(request), .done(done),
        .grant(g_c), .grant_idx(i_c), .valid(v_c));

    logic [3:0] sbq[$];
    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [1:0] oh_idx(input logic [3:0] g);
        logic [1:0] r;
        r = 2'd0;
        for (int k = 0; k < 4; k++) if (g[k]) r = 2'(k);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        n_reset = 1'b0; request = 4'b0; done = 1'b0;
        tick();
        n_reset = 1'b1;
    endtask

    task automatic test_reset();
        logic [3:0] e;
        n_reset = 1'b0; request = 4'b1111; done = 1'b0;
        for (int c = 0; c < 3; c++) begin
            sbq.push_back(4'b0000);
            tick();
            e = sbq.pop_front();
            n_checks++;
            if (g_a !== e || v_a !== 1'b0 || i_a !== 2'd0) begin
                n_fail++;
                $display("FAIL reset cyc%0d: grant=%b valid=%b idx=%0d, want grant=%b valid=0 idx=0", c, g_a, v_a, i_a, e);
            end
        end
        n_reset = 1'b1;
        sbq.push_back(4'b0001);
        tick();
        e = sbq.pop_front();
        n_checks++;
        if (g_a !== e || v_a !== 1'b1 || i_a !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_release: grant=%b valid=%b idx=%0d, want grant=%b valid=1 idx=0", g_a, v_a, i_a, e);
        end
    endtask

    task automatic test_rotate_handover();
        logic [3:0] seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic [3:0] e;
        apply_reset();
        request = 4'b1111; done = 1'b1;
        for (int c = 0; c < 5; c++) begin
            sbq.push_back(seq[c]);
            tick();
            e = sbq.pop_front();
            n_checks++;
            if (g_a !== e || v_a !== 1'b1 || i_a !== oh_idx(e)) begin
                n_fail++;
                $display("FAIL rotate_handover cyc%0d: grant=%b valid=%b idx=%0d, want grant=%b", c, g_a, v_a, i_a, e);
            end
        end
    endtask

    task automatic test_rotate_idle();
        logic [3:0] seq [9] = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                                4'b0000, 4'b1000, 4'b0000, 4'b0001};
        logic [3:0] e;
        apply_reset();
        request = 4'b1111; done = 1'b1;
        for (int c = 0; c < 9; c++) begin
            sbq.push_back(seq[c]);
            tick();
            e = sbq.pop_front();
            n_checks++;
            if (g_b !== e || v_b !== (|e) || ((|e) && i_b !== oh_idx(e))) begin
                n_fail++;
                $display("FAIL rotate_idle cyc%0d: grant=%b valid=%b idx=%0d, want grant=%b", c, g_b, v_b, i_b, e);
            end
        end
    endtask

    task automatic test_no_timeout();
        logic [3:0] e;
        apply_reset();
        request = 4'b0011; done = 1'b0;
        for (int c = 0; c < 11; c++) begin
            sbq.push_back(4'b0001);
            tick();
            e = sbq.pop_front();
            n_checks++;
            if (g_a !== e || v_a !== 1'b1) begin
                n_fail++;
                $display("FAIL no_timeout cyc%0d: grant=%b valid=%b, want grant=%b", c, g_a, v_a, e);
            end
        end
    endtask

    task automatic test_timeout();
        logic [3:0] e;
        apply_reset();
        request = 4'b0011; done = 1'b0;
        for (int c = 0; c < 9; c++) begin
            sbq.push_back(c < 4 ? 4'b0001 : (c < 8 ? 4'b0010 : 4'b0001));
            tick();
            e = sbq.pop_front();
            n_checks++;
            if (g_c !== e || v_c !== 1'b1 || i_c !== oh_idx(e)) begin
                n_fail++;
                $display("FAIL timeout cyc%0d: grant=%b idx=%0d, want grant=%b", c, g_c, i_c, e);
            end
        end
    endtask

    task automatic test_wrap();
        logic [3:0] reqs [4] = '{4'b0100, 4'b1100, 4'b1000, 4'b0001};
        logic [3:0] seq  [4] = '{4'b0100, 4'b0100, 4'b1000, 4'b0001};
        logic [1:0] ptrs [4] = '{2'd0, 2'd0, 2'd3, 2'd0};
        logic [3:0] e;
        apply_reset();
        done = 1'b0;
        for (int c = 0; c < 4; c++) begin
            request = reqs[c];
            sbq.push_back(seq[c]);
            tick();
            e = sbq.pop_front();
            n_checks++;
            if (g_a !== e || i_a !== oh_idx(e) || dut_a.ptr_q !== ptrs[c]) begin
                n_fail++;
                $display("FAIL wrap cyc%0d: grant=%b idx=%0d ptr=%0d, want grant=%b ptr=%0d", c, g_a, i_a, dut_a.ptr_q, e, ptrs[c]);
            end
        end
    endtask

    task automatic test_reset_mid_grant();
        logic [3:0] e;
        apply_reset();
        done = 1'b0;
        request = 4'b0001;
        tick();
        request = 4'b0010;                // owner 0 drops, hands over to 1, ptr=1
        sbq.push_back(4'b0010);
        tick();
        e = sbq.pop_front();
        n_checks++;
        if (g_a !== e || dut_a.ptr_q !== 2'd1) begin
            n_fail++;
            $display("FAIL midreset_pre: grant=%b ptr=%0d, want grant=%b ptr=1", g_a, dut_a.ptr_q, e);
        end
        n_reset = 1'b0; request = 4'b1010;
        sbq.push_back(4'b0000);
        tick();
        e = sbq.pop_front();
        n_checks++;
        if (g_a !== e || v_a !== 1'b0 || dut_a.ptr_q !== 2'd0) begin
            n_fail++;
            $display("FAIL midreset_drop: grant=%b valid=%b ptr=%0d, want grant=%b valid=0 ptr=0", g_a, v_a, dut_a.ptr_q, e);
        end
        n_reset = 1'b1;
        sbq.push_back(4'b0010);
        tick();
        e = sbq.pop_front();
        n_checks++;
        if (g_a !== e || v_a !== 1'b1 || i_a !== 2'd1) begin
            n_fail++;
            $display("FAIL midreset_regrant: grant=%b valid=%b idx=%0d, want grant=%b", g_a, v_a, i_a, e);
        end
    endtask

    // A lone requester with done held high is never re-granted on its own release edge.
    task automatic test_back_to_back();
        logic [3:0] e;
        apply_reset();
        request = 4'b0001; done = 1'b1;
        for (int c = 0; c < 4; c++) begin
            sbq.push_back(c[0] ? 4'b0000 : 4'b0001);
            tick();
            e = sbq.pop_front();
            n_checks++;
            if (g_a !== e || v_a !== (|e)) begin
                n_fail++;
                $display("FAIL back_to_back cyc%0d: grant=%b valid=%b, want grant=%b", c, g_a, v_a, e);
            end
        end
    endtask

    initial begin
        n_reset = 1'b0; request = 4'b0; done = 1'b0;
        test_reset();
        test_rotate_handover();
        test_rotate_idle();
        test_no_timeout();
        test_timeout();
        test_wrap();
        test_reset_mid_grant();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
